fxp_divide: RTL and testbench
=============================

Name: fxp_divide

Overview:
- Sequential signed fixed-point divider: quot = round(num / den), with num, den and quot all in Q1.(BIT_WIDTH-1).
- It is the inverse of the combinational Q1.15 multiply unit.
- It is used where the datapath must normalise, e.g. spectral peak ratios for frequency interpolation.
- Restoring radix-2 iteration, one quotient bit per cycle, fixed latency, start/done handshake.

Parameters:
- BIT_WIDTH, 16, operand and quotient width in bits; format Q1.(BIT_WIDTH-1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; operands are sampled on a rising edge when start=1 and busy=0
- num  input  BIT_WIDTH  signed dividend
- den  input  BIT_WIDTH  signed divisor
- busy  output  1  high from the cycle after start is accepted until done is asserted
- done  output  1  one-cycle pulse; quot and flags are valid from this cycle
- quot  output  BIT_WIDTH  signed rounded, saturated quotient
- div_zero  output  1  den was 0 for this result
- ovf  output  1  true quotient was not representable and quot was saturated

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over everything, including mid-operation.
  - Forces state=IDLE, busy=0, done=0, quot=0, div_zero=0, ovf=0, and clears the counter.
  - Any in-flight result is discarded.
- States: IDLE -> DIV -> FINISH -> IDLE.
- IDLE:
  - On start=1, latch sign = num[MSB] ^ den[MSB].
  - Latch |num| and |den| as BIT_WIDTH-bit unsigned values; |-2^(BIT_WIDTH-1)| = 2^(BIT_WIDTH-1) must be representable.
  - Latch den_zero (den==0), num_zero, and precheck flags:
    - big: |num| > |den|, or |num| == |den| with sign=0
    - neg_one: |num| == |den| != 0 with sign=1
  - Set rem=|num| (BIT_WIDTH+1 bits), q=0, cnt=BIT_WIDTH; go to DIV.
- DIV:
  - Each cycle: rem' = rem<<1; if rem' >= |den| then { rem' -= |den|; qbit=1 } else qbit=0.
  - q = {q[BIT_WIDTH-2:0], qbit}; cnt decrements.
  - After BIT_WIDTH cycles go to FINISH.
  - q is Q0.BIT_WIDTH: BIT_WIDTH-1 fraction bits plus one rounding bit.
  - The iterations always run, even for special cases, to keep latency constant.
- FINISH:
  - Compute mag = (q>>1) + q[0]: round half away from zero, applied on the magnitude.
  - Priority order for the result:
    1. den_zero: quot = num_zero ? 0 : (num>=0 ? MAX : MIN); div_zero=1; ovf=0.
    2. neg_one: quot = MIN; ovf=0.
    3. big: quot = sign ? MIN : MAX; ovf=1.
    4. mag == 2^(BIT_WIDTH-1): quot = sign ? MIN : MAX; ovf = ~sign.
    5. Otherwise: quot = sign ? -mag : mag; ovf=0.
  - Assert done for 1 cycle, drop busy, return to IDLE.
  - MAX = 0x7FFF and MIN = 0x8000 for BIT_WIDTH=16.
- Latency:
  - start accepted at edge k gives done high in the cycle following edge k+BIT_WIDTH+1 (18 edges for 16-bit).
  - Throughput: one division per BIT_WIDTH+2 cycles.
- Handshake:
  - start while busy is ignored, and the operand registers are not disturbed.
  - start may be asserted in the same cycle done is high; the FSM is then in IDLE and accepts it.
  - quot, div_zero and ovf hold their last values until the next FINISH; they do not return to 0 after done.
- num/den changing after acceptance has no effect.

Decomposition:
- Package fxp_pkg:
  - default FXP_WIDTH=16
  - FXP_MAX/FXP_MIN constants (as functions of width)
  - enum div_state_t {IDLE, DIV, FINISH}
- One natural sub-module, fxp_round_sat:
  - Combinational: takes q, sign and the flags; produces quot, ovf and div_zero.
  - Isolates the FINISH arithmetic so it can be unit-tested against a reference model.
- Iteration datapath and FSM stay in fxp_divide.

Test Plan:
- Basic division: num=0x2000, den=0x4000 -> quot=0x4000, ovf=0, div_zero=0.
  - Also check: done asserted exactly 18 cycles after the start edge, busy high for 17 cycles.
- Sign and rounding:
  - num=0xE000, den=0x4000 -> quot=0xC000.
  - num=0x0001, den=0x0003 -> quot=0x2AAB (round-up path).
  - num=0xFFFF, den=0x0003 -> quot=0xD555.
- Divide by zero:
  - num=0x1234, den=0 -> quot=0x7FFF, div_zero=1, ovf=0.
  - num=0x8000, den=0 -> 0x8000, div_zero=1.
  - num=0, den=0 -> 0x0000, div_zero=1.
- Saturation:
  - num=0x6000, den=0x2000 -> 0x7FFF, ovf=1.
  - num=0x4000, den=0xC000 -> 0x8000, ovf=0.
  - num=0x8000, den=0x8000 -> 0x7FFF, ovf=1.
- Handshake:
  - A second start with different operands at cycle 5 of busy is ignored; the result matches the first operands.
  - start held high on the done cycle launches a back-to-back op; its done follows 18 cycles later.
- Reset mid-operation:
  - Assert reset at cycle 8 of DIV -> next cycle busy=0, done=0, quot=0, flags=0.
  - A new start then completes correctly with no residual state.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared types and constants for the signed fixed-point divider.
package fxp_pkg;

  localparam int FXP_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  // Operand properties captured at start; they steer the result selection.
  typedef struct packed {
    logic den_zero;
    logic num_zero;
    logic big;
    logic neg_one;
  } div_flags_t;

  function automatic logic [63:0] fxp_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fxp_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

  localparam logic [FXP_WIDTH-1:0] FXP_MAX = FXP_WIDTH'(fxp_max(FXP_WIDTH));
  localparam logic [FXP_WIDTH-1:0] FXP_MIN = FXP_WIDTH'(fxp_min(FXP_WIDTH));

endpackage

// File: rtl/fxp_divide_if.sv
// Start/done handshake and operand/result bus of the fixed-point divider.
interface fxp_divide_if
  import fxp_pkg::*;
#(
  parameter int BIT_WIDTH = FXP_WIDTH
);
  logic                 start;
  logic [BIT_WIDTH-1:0] num;
  logic [BIT_WIDTH-1:0] den;
  logic                 busy;
  logic                 done;
  logic [BIT_WIDTH-1:0] quot;
  logic                 div_zero;
  logic                 ovf;

  modport master (
    output start, num, den,
    input  busy, done, quot, div_zero, ovf
  );

  modport slave (
    input  start, num, den,
    output busy, done, quot, div_zero, ovf
  );
endinterface

// File: rtl/fxp_round_sat.sv
// Turns the raw Q0.N quotient magnitude plus operand flags into the final
// rounded, saturated signed quotient and its status flags.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int BIT_WIDTH = FXP_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] q_i,
  input  logic                 sign_i,
  input  div_flags_t           flags_i,
  output logic [BIT_WIDTH-1:0] quot_o,
  output logic                 ovf_o,
  output logic                 div_zero_o
);
  typedef logic [BIT_WIDTH-1:0] word_t;

  localparam word_t MAX_V = BIT_WIDTH'(fxp_max(BIT_WIDTH));
  localparam word_t MIN_V = BIT_WIDTH'(fxp_min(BIT_WIDTH));

  word_t mag;
  word_t mag_neg;

  // Low quotient bit is the half-LSB; adding it rounds half away from zero.
  assign mag     = {1'b0, q_i[BIT_WIDTH-1:1]} + word_t'(q_i[0]);
  assign mag_neg = ~mag + word_t'(1);

  always_comb begin
    quot_o     = '0;
    ovf_o      = 1'b0;
    div_zero_o = 1'b0;
    if (flags_i.den_zero) begin
      // den is zero, so sign_i is simply the sign of num here.
      div_zero_o = 1'b1;
      if (flags_i.num_zero) begin
        quot_o = '0;
      end else begin
        quot_o = sign_i ? MIN_V : MAX_V;
      end
    end else if (flags_i.neg_one) begin
      quot_o = MIN_V;
    end else if (flags_i.big) begin
      quot_o = sign_i ? MIN_V : MAX_V;
      ovf_o  = 1'b1;
    end else if (mag == MIN_V) begin
      quot_o = sign_i ? MIN_V : MAX_V;
      ovf_o  = ~sign_i;
    end else begin
      quot_o = sign_i ? mag_neg : mag;
    end
  end

endmodule

// File: rtl/fxp_divide.sv
// Sequential signed Q1.(N-1) divider: restoring radix-2, one quotient bit per
// cycle, constant latency regardless of operand values.
module fxp_divide
  import fxp_pkg::*;
#(
  parameter int BIT_WIDTH = FXP_WIDTH
) (
  input logic         clk,
  input logic         reset,
  fxp_divide_if.slave bus
);
  localparam int CNT_W = $clog2(BIT_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef logic [BIT_WIDTH-1:0] word_t;
  typedef logic [BIT_WIDTH:0]   rem_t;
  typedef logic [BIT_WIDTH+1:0] wide_t;

  div_state_t       state_q, state_d;
  logic             sign_q, sign_d;
  word_t            den_abs_q, den_abs_d;
  rem_t             rem_q, rem_d;
  word_t            q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  div_flags_t       flags_q, flags_d;
  word_t            quot_q, quot_d;
  logic             div_zero_q, div_zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  word_t num_abs_in;
  word_t den_abs_in;
  logic  sign_in;
  wide_t rem_shift;
  wide_t den_ext;
  wide_t rem_next;
  logic  qbit;
  word_t rs_quot;
  logic  rs_ovf;
  logic  rs_div_zero;

  // Unsigned magnitude; the most negative value maps to 2^(N-1), which fits.
  function automatic word_t abs_val(input word_t x);
    return x[BIT_WIDTH-1] ? (~x + word_t'(1)) : x;
  endfunction

  assign num_abs_in = abs_val(bus.num);
  assign den_abs_in = abs_val(bus.den);
  assign sign_in    = bus.num[BIT_WIDTH-1] ^ bus.den[BIT_WIDTH-1];

  assign rem_shift = {rem_q, 1'b0};
  assign den_ext   = {2'b00, den_abs_q};
  assign qbit      = (rem_shift >= den_ext);
  assign rem_next  = qbit ? (rem_shift - den_ext) : rem_shift;

  fxp_round_sat #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_round_sat (
    .q_i       (q_q),
    .sign_i    (sign_q),
    .flags_i   (flags_q),
    .quot_o    (rs_quot),
    .ovf_o     (rs_ovf),
    .div_zero_o(rs_div_zero)
  );

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    den_abs_d  = den_abs_q;
    rem_d      = rem_q;
    q_d        = q_q;
    cnt_d      = cnt_q;
    flags_d    = flags_q;
    quot_d     = quot_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d           = sign_in;
          den_abs_d        = den_abs_in;
          rem_d            = {1'b0, num_abs_in};
          q_d              = '0;
          cnt_d            = CNT_INIT;
          flags_d.den_zero = (bus.den == '0);
          flags_d.num_zero = (bus.num == '0);
          flags_d.big      = (num_abs_in > den_abs_in) ||
                             ((num_abs_in == den_abs_in) && !sign_in);
          flags_d.neg_one  = (num_abs_in == den_abs_in) &&
                             (den_abs_in != '0) && sign_in;
          state_d          = DIV;
        end
      end
      DIV: begin
        // Overflow-prone cases still iterate; their q is ignored at FINISH.
        rem_d = rem_t'(rem_next);
        q_d   = {q_q[BIT_WIDTH-2:0], qbit};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        quot_d     = rs_quot;
        div_zero_d = rs_div_zero;
        ovf_d      = rs_ovf;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      den_abs_q  <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      flags_q    <= '0;
      quot_q     <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      den_abs_q  <= den_abs_d;
      rem_q      <= rem_d;
      q_q        <= q_d;
      cnt_q      <= cnt_d;
      flags_q    <= flags_d;
      quot_q     <= quot_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.quot     = quot_q;
  assign bus.div_zero = div_zero_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_fxp_divide.sv
// Randomised and directed checks of fxp_divide against an arithmetic
// reference (rounded real quotient, then clamped to the Q1.15 range).
module tb_fxp_divide;
  localparam int W        = 16;
  localparam int LAT      = W + 1;
  localparam int BUSY_CYC = W + 1;
  localparam int TIMEOUT  = 40;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_ops    = 0;

  fxp_divide_if #(.BIT_WIDTH(W)) bus ();

  fxp_divide #(.BIT_WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {div_zero, ovf, quot}.
  function automatic logic [17:0] ref_div(input logic [15:0] n, input logic [15:0] d);
    longint ni, di, an, ad, mag, r;
    logic   s, dz, ov;
    ni = longint'($signed(n));
    di = longint'($signed(d));
    dz = 1'b0;
    ov = 1'b0;
    if (di == 0) begin
      dz = 1'b1;
      if (ni == 0)     r = 0;
      else if (ni > 0) r = 32767;
      else             r = -32768;
    end else begin
      an  = (ni < 0) ? -ni : ni;
      ad  = (di < 0) ? -di : di;
      s   = (ni < 0) != (di < 0);
      mag = (an * 65536 + ad) / (2 * ad);
      r   = s ? -mag : mag;
      if (r > 32767) begin
        r  = 32767;
        ov = 1'b1;
      end else if (r < -32768) begin
        r  = -32768;
        ov = 1'b1;
      end
    end
    return {dz, ov, 16'(r)};
  endfunction

  // Launches one division and waits for done; optionally pokes a second
  // start with other operands while busy (intr_at = busy cycle index, -1 = none).
  task automatic do_div(input logic [15:0] n, input logic [15:0] d, input int intr_at,
                        input logic [15:0] n2, input logic [15:0] d2);
    logic [17:0] exp;
    int          cyc;
    int          busy_cnt;
    string       pfx;
    exp = ref_div(n, d);
    n_ops++;
    pfx = $sformatf("op%0d", n_ops);
    bus.num   = n;
    bus.den   = d;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.num   = 16'($urandom);
    bus.den   = 16'($urandom);
    cyc       = 0;
    busy_cnt  = 0;
    while (bus.done !== 1'b1 && cyc < TIMEOUT) begin
      if (bus.busy === 1'b1) busy_cnt++;
      bus.start = (cyc == intr_at);
      if (cyc == intr_at) begin
        bus.num = n2;
        bus.den = d2;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    check_eq({pfx, ".latency"}, cyc, LAT);
    check_eq({pfx, ".busy_len"}, busy_cnt, BUSY_CYC);
    check_eq({pfx, ".busy_at_done"}, bus.busy, 1'b0);
    check_eq({pfx, ".quot"}, bus.quot, exp[15:0]);
    check_eq({pfx, ".div_zero"}, bus.div_zero, exp[17]);
    check_eq({pfx, ".ovf"}, bus.ovf, exp[16]);
    $display("op %0d num=%h den=%h quot=%h dz=%b ovf=%b lat=%0d exp=%h/%b/%b",
             n_ops, n, d, bus.quot, bus.div_zero, bus.ovf, cyc, exp[15:0], exp[17], exp[16]);
  endtask

  logic [15:0] dir_num  [10] = '{16'h2000, 16'hE000, 16'h0001, 16'hFFFF, 16'h1234,
                                 16'h8000, 16'h0000, 16'h6000, 16'h4000, 16'h8000};
  logic [15:0] dir_den  [10] = '{16'h4000, 16'h4000, 16'h0003, 16'h0003, 16'h0000,
                                 16'h0000, 16'h0000, 16'h2000, 16'hC000, 16'h8000};
  logic [15:0] dir_quot [10] = '{16'h4000, 16'hC000, 16'h2AAB, 16'hD555, 16'h7FFF,
                                 16'h8000, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF};
  logic [15:0] edge_den [5]  = '{16'h0000, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};

  initial begin
    logic [15:0] rn;
    logic [15:0] rd;
    int          cyc;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.num   = '0;
    bus.den   = '0;
    repeat (3) tick();
    check_eq("rst.busy", bus.busy, 1'b0);
    check_eq("rst.done", bus.done, 1'b0);
    check_eq("rst.quot", bus.quot, 16'h0000);
    check_eq("rst.div_zero", bus.div_zero, 1'b0);
    check_eq("rst.ovf", bus.ovf, 1'b0);
    $display("reset released busy=%b done=%b quot=%h", bus.busy, bus.done, bus.quot);
    reset = 1'b0;
    tick();

    // Directed table; consecutive calls are back-to-back (start on done cycle).
    for (int i = 0; i < 10; i++) begin
      do_div(dir_num[i], dir_den[i], -1, 16'h0, 16'h0);
      check_eq($sformatf("dir%0d.quot", i), bus.quot, dir_quot[i]);
    end

    // Results hold after done while idle (last op saturated with ovf=1).
    repeat (3) tick();
    check_eq("hold.done", bus.done, 1'b0);
    check_eq("hold.busy", bus.busy, 1'b0);
    check_eq("hold.quot", bus.quot, 16'h7FFF);
    check_eq("hold.ovf", bus.ovf, 1'b1);
    $display("hold quot=%h ovf=%b done=%b", bus.quot, bus.ovf, bus.done);

    // Start while busy must be ignored.
    do_div(16'h1000, 16'h3000, 4, 16'h7000, 16'h0100);

    // Reset in the middle of an operation after a saturating result.
    do_div(16'h6000, 16'h2000, -1, 16'h0, 16'h0);
    bus.num   = 16'h1111;
    bus.den   = 16'h2222;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (cyc = 0; cyc < 8; cyc++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst.busy", bus.busy, 1'b0);
    check_eq("midrst.done", bus.done, 1'b0);
    check_eq("midrst.quot", bus.quot, 16'h0000);
    check_eq("midrst.div_zero", bus.div_zero, 1'b0);
    check_eq("midrst.ovf", bus.ovf, 1'b0);
    $display("midrst busy=%b done=%b quot=%h ovf=%b", bus.busy, bus.done, bus.quot, bus.ovf);
    do_div(16'h0001, 16'h0003, -1, 16'h0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          rn = 16'($urandom);
          rd = 16'($urandom);
        end
        1: begin
          rd = 16'($urandom);
          rn = 16'($urandom_range(0, 255));
          if ($urandom_range(0, 1) == 1) rn = -rn;
        end
        2: begin
          rn = 16'($urandom);
          rd = edge_den[$urandom_range(0, 4)];
        end
        default: begin
          rd = 16'($urandom);
          rn = ($urandom_range(0, 1) == 1) ? rd : -rd;
        end
      endcase
      do_div(rn, rd, -1, 16'h0, 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
